// File: rtl/fight_pkg.sv
// Shared fight-screen constants: state codes, cursor codes, HP and the
// default skill damage table. Used by the controller and the renderer.
package fight_pkg;

    typedef enum logic [5:0] {
        ST_MENU     = 6'd1,
        ST_CHOOSE   = 6'd2,
        ST_ANIM_P1  = 6'd3,
        ST_ANIM_P2  = 6'd4,
        ST_HPRED_P1 = 6'd5,
        ST_HPRED_P2 = 6'd6,
        ST_OVER     = 6'd7
    } fight_state_e;

    typedef enum logic [3:0] {
        OPT_TL = 4'd1,
        OPT_TR = 4'd2,
        OPT_BL = 4'd3,
        OPT_BR = 4'd4
    } option_e;

    localparam int unsigned FIGHT_MAX_HP = 200;

    localparam logic [7:0] FIGHT_DMG1 = 8'd10;
    localparam logic [7:0] FIGHT_DMG2 = 8'd20;
    localparam logic [7:0] FIGHT_DMG3 = 8'd30;
    localparam logic [7:0] FIGHT_DMG4 = 8'd40;

    // Cursor as a 2x2 grid: vertical picks the row, horizontal the column,
    // opposing pulses cancel, no wrap. Unknown codes fall back to top-left.
    function automatic logic [3:0] opt_move(input logic [3:0] opt,
                                            input logic up, input logic dn,
                                            input logic lf, input logic rt);
        logic row;
        logic col;
        row = (opt == OPT_BL) || (opt == OPT_BR);
        col = (opt == OPT_TR) || (opt == OPT_BR);
        if (up && !dn) row = 1'b0;
        if (dn && !up) row = 1'b1;
        if (lf && !rt) col = 1'b0;
        if (rt && !lf) col = 1'b1;
        return {2'b00, row, col} + 4'd1;
    endfunction

endpackage

// File: rtl/fight_controller_if.sv
// Button/tick inputs and fight-screen outputs of the fight controller.
// slave = the controller, master = whoever drives buttons and reads state.
interface fight_controller_if;
    logic       tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_enter;
    logic [5:0] fight_state;
    logic [3:0] option_state;
    logic [7:0] p1_cur_hp;
    logic [7:0] p2_cur_hp;
    logic [1:0] winner;
    logic [2:0] p2_skill;

    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right, btn_enter,
        input  fight_state, option_state, p1_cur_hp, p2_cur_hp, winner, p2_skill
    );

    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right, btn_enter,
        output fight_state, option_state, p1_cur_hp, p2_cur_hp, winner, p2_skill
    );
endinterface

// File: rtl/fight_controller_p2_skill_gen.sv
// P2 skill source. With FIGHT_P2_RANDOM_EN defined: 8-bit Fibonacci LFSR
// (taps 8,6,5,4, seed A5) stepping every clock, skill = lfsr[1:0]+1.
// Otherwise a 1->2->3->4 round-robin stepped once per P2 attack.
module p2_skill_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       restart,
    output logic [2:0] skill
);
`ifdef FIGHT_P2_RANDOM_EN
    logic [7:0] lfsr_q;
    logic       unused_advance;

    assign unused_advance = advance;

    // Free-running LFSR, reseeded on a game restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lfsr_q <= 8'hA5;
        else if (restart) lfsr_q <= 8'hA5;
        else              lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign skill = {1'b0, lfsr_q[1:0]} + 3'd1;
`else
    logic [2:0] rr_q;

    // Round-robin pointer; holds the skill the next P2 attack will use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rr_q <= 3'd1;
        else if (restart) rr_q <= 3'd1;
        else if (advance) rr_q <= (rr_q >= 3'd4) ? 3'd1 : rr_q + 3'd1;
    end

    assign skill = rr_q;
`endif
endmodule

// File: rtl/fight_controller.sv
// Fight turn controller: cursor, skill pick, attack animations and HP drain
// for both players. Optional macro FIGHT_P2_RANDOM_EN selects the random
// P2 skill source inside p2_skill_gen.
module fight_controller
    import fight_pkg::*;
#(
    parameter int unsigned MAX_HP     = FIGHT_MAX_HP,
    parameter int unsigned ANIM_TICKS = 30,
    parameter logic [7:0]  DMG1       = FIGHT_DMG1,
    parameter logic [7:0]  DMG2       = FIGHT_DMG2,
    parameter logic [7:0]  DMG3       = FIGHT_DMG3,
    parameter logic [7:0]  DMG4       = FIGHT_DMG4
) (
    input logic               clk,
    input logic               rst_n,
    fight_controller_if.slave bus
);
    localparam logic [7:0]  MAX_HP8 = 8'(MAX_HP);
    localparam logic [15:0] ANIM_T  = 16'(ANIM_TICKS);

    fight_state_e state_q;
    logic [3:0]   opt_q;
    logic [7:0]   hp1_q, hp2_q, dmg_q;
    logic [1:0]   winner_q;
    logic [2:0]   p2s_q;
    logic [15:0]  cnt_q;

    logic         enter, tick;
    logic [3:0]   opt_d;
    logic [7:0]   tgt_hp, hp_dec;
    logic         drain_done, drain_kill;
    logic         gen_adv, gen_restart;
    logic [2:0]   gen_skill;

    assign enter = bus.btn_enter;
    assign tick  = bus.tick;
    assign opt_d = opt_move(opt_q, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right);

    function automatic logic [7:0] dmg_of(input logic [3:0] sel);
        case (sel)
            4'd1:    return DMG1;
            4'd2:    return DMG2;
            4'd3:    return DMG3;
            4'd4:    return DMG4;
            default: return DMG1;
        endcase
    endfunction

    // One drain step for whichever player is losing HP. A zero remaining
    // damage exits without touching HP; hitting 0 HP ends the game.
    always_comb begin
        tgt_hp     = (state_q == ST_HPRED_P2) ? hp2_q : hp1_q;
        hp_dec     = (tgt_hp != 8'd0) ? tgt_hp - 8'd1 : 8'd0;
        drain_done = tick && ((dmg_q == 8'd0) || ((hp_dec != 8'd0) && (dmg_q == 8'd1)));
        drain_kill = tick && (dmg_q != 8'd0) && (hp_dec == 8'd0);
    end

    // The generator steps exactly when P2's attack begins
    assign gen_adv     = (state_q == ST_HPRED_P2) && drain_done;
    assign gen_restart = (state_q == ST_OVER) && enter;

    p2_skill_gen u_skill (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (gen_adv),
        .restart (gen_restart),
        .skill   (gen_skill)
    );

    // Turn FSM with all fight-screen outputs held in registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_MENU;
            opt_q    <= OPT_TL;
            hp1_q    <= MAX_HP8;
            hp2_q    <= MAX_HP8;
            winner_q <= 2'd0;
            p2s_q    <= 3'd0;
            dmg_q    <= 8'd0;
            cnt_q    <= 16'd0;
        end else begin
            case (state_q)
                ST_MENU: begin
                    if (enter) begin
                        // options 2-4 are reserved: enter there does nothing
                        if (opt_q == OPT_TL) begin
                            state_q <= ST_CHOOSE;
                            opt_q   <= OPT_TL;
                        end
                    end else begin
                        opt_q <= opt_d;
                    end
                end
                ST_CHOOSE: begin
                    if (enter) begin
                        dmg_q   <= dmg_of(opt_q);
                        opt_q   <= OPT_TL;
                        cnt_q   <= 16'd0;
                        state_q <= ST_ANIM_P1;
                    end else begin
                        opt_q <= opt_d;
                    end
                end
                ST_ANIM_P1, ST_ANIM_P2: begin
                    if (tick) begin
                        if (cnt_q + 16'd1 >= ANIM_T) begin
                            cnt_q   <= 16'd0;
                            state_q <= (state_q == ST_ANIM_P1) ? ST_HPRED_P2 : ST_HPRED_P1;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                ST_HPRED_P1, ST_HPRED_P2: begin
                    if (tick) begin
                        if (dmg_q != 8'd0) begin
                            dmg_q <= dmg_q - 8'd1;
                            if (state_q == ST_HPRED_P2) hp2_q <= hp_dec;
                            else                        hp1_q <= hp_dec;
                        end
                        if (drain_kill) begin
                            state_q  <= ST_OVER;
                            winner_q <= (state_q == ST_HPRED_P2) ? 2'd1 : 2'd2;
                        end else if (drain_done) begin
                            if (state_q == ST_HPRED_P2) begin
                                state_q <= ST_ANIM_P2;
                                p2s_q   <= gen_skill;
                                dmg_q   <= dmg_of({1'b0, gen_skill});
                                cnt_q   <= 16'd0;
                            end else begin
                                state_q <= ST_MENU;
                                opt_q   <= OPT_TL;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (enter) begin
                        state_q  <= ST_MENU;
                        opt_q    <= OPT_TL;
                        hp1_q    <= MAX_HP8;
                        hp2_q    <= MAX_HP8;
                        winner_q <= 2'd0;
                        p2s_q    <= 3'd0;
                        dmg_q    <= 8'd0;
                        cnt_q    <= 16'd0;
                    end
                end
                default: begin
                    state_q <= ST_MENU;
                    opt_q   <= OPT_TL;
                end
            endcase
        end
    end

    assign bus.fight_state  = state_q;
    assign bus.option_state = opt_q;
    assign bus.p1_cur_hp    = hp1_q;
    assign bus.p2_cur_hp    = hp2_q;
    assign bus.winner       = winner_q;
    assign bus.p2_skill     = p2s_q;

endmodule

// File: tb/tb_fight_controller.sv
// Bench for fight_controller (default build, round-robin P2 skills).
// Expected values come from a turn-level model: cursor as row/column,
// attacks as "N ticks of animation, then min(dmg, hp) ticks of drain".
module tb_fight_controller;
    localparam int MAXHP = 200;
    localparam int ANIM  = 30;
    localparam logic [4:0] BE = 5'b10000;
    localparam logic [4:0] BU = 5'b01000;
    localparam logic [4:0] BD = 5'b00100;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BR = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fight_controller_if ifc();
    fight_controller dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int checks = 0;
    int failures = 0;
    int dmg_t[4] = '{10, 20, 30, 40};
    int m_state, m_opt, m_hp1, m_hp2, m_win, m_p2s, m_rr;
    logic [4:0] seq[6];
    int         seq_exp[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".state"}, 32'(ifc.fight_state), m_state);
        chk({tag, ".opt"},   32'(ifc.option_state), m_opt);
        chk({tag, ".hp1"},   32'(ifc.p1_cur_hp), m_hp1);
        chk({tag, ".hp2"},   32'(ifc.p2_cur_hp), m_hp2);
        chk({tag, ".win"},   32'(ifc.winner), m_win);
        chk({tag, ".p2s"},   32'(ifc.p2_skill), m_p2s);
    endtask

    task automatic model_reset();
        m_state = 1; m_opt = 1; m_hp1 = MAXHP; m_hp2 = MAXHP;
        m_win = 0; m_p2s = 0; m_rr = 1;
    endtask

    // One clock with the given button pulses {enter,up,down,left,right} and tick
    task automatic cyc(input logic [4:0] b, input logic t);
        @(negedge clk);
        {ifc.btn_enter, ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right} = b;
        ifc.tick = t;
        @(posedge clk);
        #1;
        {ifc.btn_enter, ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right} = 5'b0;
        ifc.tick = 1'b0;
    endtask

    function automatic int mv(input int opt, input logic [4:0] b);
        int r, c;
        r = (opt - 1) / 2;
        c = (opt - 1) % 2;
        if (b[3] && !b[2]) r = 0;
        if (b[2] && !b[3]) r = 1;
        if (b[1] && !b[0]) c = 0;
        if (b[0] && !b[1]) c = 1;
        return 2 * r + c + 1;
    endfunction

    // Button press in MENU/CHOOSING (enter in CHOOSING is handled by turn)
    task automatic menu_press(input logic [4:0] b);
        cyc(b, 1'b0);
        if (b[4]) begin
            if (m_state == 1 && m_opt == 1) begin m_state = 2; m_opt = 1; end
        end else begin
            m_opt = mv(m_opt, b);
        end
        chk_all("menu");
    endtask

    // Random non-tick cycles with random buttons; nothing may change
    task automatic noise();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            cyc(5'($urandom_range(0, 31)), 1'b0);
            chk_all("ignore");
        end
    endtask

    task automatic attack(input int who, input int d);
        int hp0, n;
        for (int k = 1; k <= ANIM; k++) begin
            noise();
            cyc(5'b0, 1'b1);
            if (k == ANIM) m_state = (who == 1) ? 6 : 5;
            chk_all("anim");
        end
        hp0 = (who == 1) ? m_hp2 : m_hp1;
        n = (d < hp0) ? d : hp0;
        for (int k = 1; k <= n; k++) begin
            noise();
            cyc(5'b0, 1'b1);
            if (who == 1) m_hp2 = hp0 - k; else m_hp1 = hp0 - k;
            if (k == n) begin
                if (hp0 - k == 0) begin
                    m_state = 7; m_win = who;
                end else if (who == 1) begin
                    m_state = 4; m_p2s = m_rr; m_rr = m_rr % 4 + 1;
                end else begin
                    m_state = 1; m_opt = 1;
                end
            end
            chk_all("drain");
        end
    endtask

    task automatic to_choose();
        if (m_state == 1) begin
            menu_press(BU | BL);
            menu_press(BE);
        end
    endtask

    // P1 picks skill s, then both attacks play out as far as the game lasts
    task automatic turn(input int s);
        int r, c;
        r = (s - 1) / 2;
        c = (s - 1) % 2;
        menu_press((r != 0 ? BD : BU) | (c != 0 ? BR : BL));
        cyc(BE, 1'b0);
        m_state = 3; m_opt = 1;
        chk_all("pick");
        attack(1, dmg_t[s-1]);
        if (m_state == 4) attack(2, dmg_t[m_p2s-1]);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int turns;
        {ifc.btn_enter, ifc.btn_up, ifc.btn_down, ifc.btn_left, ifc.btn_right} = 5'b0;
        ifc.tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk_all("in_reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (5) cyc(5'b0, 1'b0);
        chk_all("reset_idle");

        // directed cursor walk
        seq = '{BR, BD, BD, BR, BU | BD, BL | BU};
        seq_exp = '{2, 4, 4, 4, 4, 1};
        for (int i = 0; i < 6; i++) begin
            menu_press(seq[i]);
            chk("cursor_dir", 32'(ifc.option_state), seq_exp[i]);
        end
        // enter on a reserved option is a no-op and beats the direction
        menu_press(BR);
        menu_press(BE | BD);
        chk("reserved_enter_state", 32'(ifc.fight_state), 1);
        chk("reserved_enter_opt", 32'(ifc.option_state), 2);

        // random cursor traffic in MENU / CHOOSING
        for (int i = 0; i < 30; i++) begin
            logic [4:0] b;
            b = 5'($urandom_range(0, 31));
            if (m_state == 2) b[4] = 1'b0;
            menu_press(b);
        end

        // first turn: skill 4 vs round-robin skill 1
        to_choose();
        turn(4);
        chk("t1_hp2", 32'(ifc.p2_cur_hp), 160);
        chk("t1_hp1", 32'(ifc.p1_cur_hp), 190);
        chk("t1_p2s", 32'(ifc.p2_skill), 1);
        chk("t1_state", 32'(ifc.fight_state), 1);

        // drive P2 down to 10, then overkill with skill 2
        begin
            int pre[5] = '{4, 4, 4, 3, 2};
            for (int i = 0; i < 5; i++) begin
                to_choose();
                turn(pre[i]);
            end
        end
        chk("sat_hp2", 32'(ifc.p2_cur_hp), 0);
        chk("sat_hp1", 32'(ifc.p1_cur_hp), 90);
        chk("sat_state", 32'(ifc.fight_state), 7);
        chk("sat_winner", 32'(ifc.winner), 1);

        // directions in OVER do nothing; enter restarts
        cyc(BU | BR, 1'b1);
        chk_all("over_hold");
        cyc(BE, 1'b0);
        model_reset();
        chk_all("restart");
        chk("restart_hp", 32'({ifc.p1_cur_hp, ifc.p2_cur_hp}), 32'({8'd200, 8'd200}));

        // random game to completion
        turns = 0;
        while (m_state != 7 && turns < 40) begin
            to_choose();
            turn($urandom_range(1, 4));
            turns++;
        end
        chk("game_over", 32'(ifc.fight_state), 7);
        cyc(BE, 1'b0);
        model_reset();
        chk_all("restart2");

        // asynchronous reset in the middle of P2's drain
        to_choose();
        menu_press(BD | BR);
        cyc(BE, 1'b0);
        for (int k = 0; k < ANIM; k++) cyc(5'b0, 1'b1);
        for (int k = 0; k < 5; k++) cyc(BE, 1'b1);
        chk("mid_hp2", 32'(ifc.p2_cur_hp), 195);
        chk("mid_state", 32'(ifc.fight_state), 6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk) rst_n = 1'b1;
        cyc(5'b0, 1'b1);
        chk_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
